pp_accumulator: RTL and testbench
=================================

PP_ACCUMULATOR -- requirements
Module: pp_accumulator

Interface
REQ-001 SHALL take parameters from multiplier_pkg: DATA_LENGTH (64, operand width), BLOCK_LENGTH (16, block width), NUM_BLOCKS (4, blocks per operand), NUM_MULS (16, partial products per result).
REQ-002 SHALL import state_t (idle, compute, finish) and counter_t from multiplier_pkg.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk_i  input  1  rising-edge clock.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 pp_valid_i  input  1  partial product offered.
REQ-007 pp_ready_o  output  1  accumulator accepts a partial product.
REQ-008 pp_data_i  input  2*BLOCK_LENGTH  partial product A[i]*B[j].
REQ-009 pp_idx_a_i  input  $clog2(NUM_BLOCKS)  block index i.
REQ-010 pp_idx_b_i  input  $clog2(NUM_BLOCKS)  block index j.
REQ-011 result_valid_o  output  1  recombined product available.
REQ-012 result_ready_i  input  1  consumer takes result.
REQ-013 result_o  output  2*DATA_LENGTH  recombined full product.
REQ-014 err_o  output  1  duplicate (i,j) seen in this result; qualified by result_valid_o.
REQ-015 busy_o  output  1  state != idle.

Function
REQ-016 Accept: pp_valid_i && pp_ready_o at a rising edge.
REQ-017 pp_ready_o SHALL be 1 in idle and compute, and 0 in finish.
REQ-018 On accept: acc <= acc + (pp_data_i << BLOCK_LENGTH*(i+j)), modulo 2^(2*DATA_LENGTH), in the same edge (1-cycle add, no pipeline).
REQ-019 On accept: count (counter_t) increments by 1 and seen[i*NUM_BLOCKS+j] is set.
REQ-020 If seen[i*NUM_BLOCKS+j] is already 1 at accept, the sticky dup flag SHALL be set, and the add SHALL still be performed.
REQ-021 idle -> compute on the first accept; that accept is added and counted.
REQ-022 compute -> finish on the accept that brings count to NUM_MULS.
REQ-023 result_valid_o SHALL be 1 in the cycle after the final accept.
REQ-024 In finish: result_valid_o = 1, result_o = acc, err_o = dup; all SHALL be held stable until result_ready_i.
REQ-025 finish && result_ready_i at an edge -> idle; acc, count, seen and dup SHALL clear in that same edge.
REQ-026 result_valid_o, err_o SHALL be 0 outside finish; result_o SHALL be 0 in idle and SHALL show the running acc in compute.
REQ-027 Partial products SHALL be accepted in any order; the final result depends only on the set of accepted products.
REQ-028 pp_valid_i asserted in finish SHALL be ignored (not accepted, no state change).
REQ-029 Back-to-back accepts (one per cycle) SHALL be supported, giving a minimum of NUM_MULS cycles plus 1 cycle to result_valid_o.
REQ-030 pp_valid_i low in compute SHALL stall indefinitely with acc held.

Reset
REQ-031 rst_ni low SHALL immediately (asynchronously) force: state idle, acc 0, count 0, seen 0, dup 0, result_valid_o 0, err_o 0, busy_o 0, pp_ready_o 1, result_o 0.
REQ-032 Reset mid-compute or mid-finish SHALL discard the partial result; the first accept after release SHALL start a fresh result.

Verification
REQ-033 Only (0,0) = 0x0000_0001; other 15 pp = 0 -> result_o = 1, err_o = 0, result_valid_o 1 cycle after the 16th accept.
REQ-034 All 16 pp = 0xFFFE_0001 (A = B = 2^64-1), sent in random order -> result_o = 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, err_o = 0.
REQ-035 (3,3) = 0xFFFF_FFFF, others 0, with result_ready_i held low 5 cycles -> result_o = 0xFFFF_FFFF << 96 held stable; pp_ready_o = 0 throughout; idle after handshake.
REQ-036 (1,2) sent twice, (3,3) omitted, all pp = 1 -> result_valid_o after the 16th accept, err_o = 1, result_o = sum of the shifted ones including the double (1,2).
REQ-037 rst_ni pulsed low after 7 accepts, then 16 fresh pp = 1 -> result_o = sum over i,j of 2^(16*(i+j)), with no residue from the first 7 accepts.
REQ-038 pp_valid_i gapped randomly (50%) and pp_valid_i held high in finish -> same result as the gap-free run, and no extra accept occurs.

Source files
------------

// File: rtl/pp_accumulator.sv
// Partial-product accumulator: sums NUM_MULS shifted block products A[i]*B[j]
// into a full 2*DATA_LENGTH product, flags duplicate (i,j) pairs, and holds the result until taken.

package multiplier_pkg;
    localparam int DATA_LENGTH  = 64;
    localparam int BLOCK_LENGTH = 16;
    localparam int NUM_BLOCKS   = 4;
    localparam int NUM_MULS     = 16;

    typedef enum logic [1:0] {
        idle    = 2'd0,
        compute = 2'd1,
        finish  = 2'd2
    } state_t;

    typedef logic [$clog2(NUM_MULS+1)-1:0] counter_t;
endpackage

module pp_accumulator
    import multiplier_pkg::*;
(
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              pp_valid_i,
    output logic                              pp_ready_o,
    input  logic [2*BLOCK_LENGTH-1:0]         pp_data_i,
    input  logic [$clog2(NUM_BLOCKS)-1:0]     pp_idx_a_i,
    input  logic [$clog2(NUM_BLOCKS)-1:0]     pp_idx_b_i,
    output logic                              result_valid_o,
    input  logic                              result_ready_i,
    output logic [2*DATA_LENGTH-1:0]          result_o,
    output logic                              err_o,
    output logic                              busy_o
);

    localparam int RESW  = 2*DATA_LENGTH;
    localparam int SEENW = NUM_BLOCKS*NUM_BLOCKS;

    state_t            state_q, state_d;
    logic [RESW-1:0]   acc_q, acc_d;
    counter_t          count_q, count_d;
    logic [SEENW-1:0]  seen_q, seen_d;
    logic              dup_q, dup_d;

    logic              accept;
    logic              last_accept;
    logic [SEENW-1:0]  pp_onehot;
    logic [RESW-1:0]   pp_ext;
    logic [RESW-1:0]   pp_shifted;

    // One-hot decode of the (i,j) pair into its seen-bit position
    genvar gi;
    generate
        for (gi = 0; gi < SEENW; gi++) begin : g_onehot
            assign pp_onehot[gi] =
                ((int'(pp_idx_a_i) * NUM_BLOCKS + int'(pp_idx_b_i)) == gi);
        end
    endgenerate

    assign pp_ext      = RESW'(pp_data_i);
    assign pp_shifted  = pp_ext << (BLOCK_LENGTH * (int'(pp_idx_a_i) + int'(pp_idx_b_i)));
    assign accept      = pp_valid_i && (state_q != finish);
    assign last_accept = accept && (count_q == counter_t'(NUM_MULS-1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            idle: begin
                if (accept) begin
                    state_d = last_accept ? finish : compute;
                end
            end
            compute: begin
                if (last_accept) begin
                    state_d = finish;
                end
            end
            finish: begin
                if (result_ready_i) begin
                    state_d = idle;
                end
            end
            default: state_d = idle;
        endcase
    end

    always_comb begin
        pp_ready_o     = (state_q != finish);
        result_valid_o = (state_q == finish);
        err_o          = (state_q == finish) && dup_q;
        busy_o         = (state_q != idle);
        result_o       = (state_q == idle) ? '0 : acc_q;
    end

    // A duplicate is still added; it only raises the sticky flag
    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        seen_d  = seen_q;
        dup_d   = dup_q;
        if (state_q == finish) begin
            if (result_ready_i) begin
                acc_d   = '0;
                count_d = '0;
                seen_d  = '0;
                dup_d   = 1'b0;
            end
        end else if (accept) begin
            acc_d   = acc_q + pp_shifted;
            count_d = count_q + 1'b1;
            seen_d  = seen_q | pp_onehot;
            dup_d   = dup_q | (|(seen_q & pp_onehot));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q   <= '0;
            count_q <= '0;
            seen_q  <= '0;
            dup_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            seen_q  <= seen_d;
            dup_q   <= dup_d;
        end
    end

endmodule

// File: tb/tb_pp_accumulator.sv
// Directed and randomized checks of pp_accumulator against a set-based model
// of the accepted partial products.

module tb_pp_accumulator;

    logic         clk;
    logic         rst_n;
    logic         pp_valid;
    logic         pp_ready;
    logic [31:0]  pp_data;
    logic [1:0]   pp_idx_a;
    logic [1:0]   pp_idx_b;
    logic         result_valid;
    logic         result_ready;
    logic [127:0] result;
    logic         err;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d;
        int          a;
        int          b;
    } pp_t;

    // Model: the multiset of accepted products plus a phase (0 idle, 1 compute, 2 finish)
    pp_t mq[$];
    int  m_phase = 0;
    pp_t pend[$];

    pp_accumulator dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .pp_valid_i     (pp_valid),
        .pp_ready_o     (pp_ready),
        .pp_data_i      (pp_data),
        .pp_idx_a_i     (pp_idx_a),
        .pp_idx_b_i     (pp_idx_b),
        .result_valid_o (result_valid),
        .result_ready_i (result_ready),
        .result_o       (result),
        .err_o          (err),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [127:0] model_sum();
        logic [127:0] s = '0;
        foreach (mq[k]) s += {96'b0, mq[k].d} << (16 * (mq[k].a + mq[k].b));
        return s;
    endfunction

    function automatic logic model_dup();
        int cnt[16];
        foreach (cnt[k]) cnt[k] = 0;
        foreach (mq[k]) cnt[mq[k].a*4 + mq[k].b]++;
        foreach (cnt[k]) if (cnt[k] > 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".ready"}, {127'b0, pp_ready},     {127'b0, m_phase != 2});
        chk({tag, ".valid"}, {127'b0, result_valid}, {127'b0, m_phase == 2});
        chk({tag, ".busy"},  {127'b0, busy},         {127'b0, m_phase != 0});
        chk({tag, ".err"},   {127'b0, err},          {127'b0, (m_phase == 2) && model_dup()});
        chk({tag, ".result"}, result, (m_phase == 0) ? 128'b0 : model_sum());
    endtask

    task automatic step(input logic v, input logic [31:0] d, input int a, input int b,
                        input logic rr);
        @(negedge clk);
        pp_valid     = v;
        pp_data      = d;
        pp_idx_a     = 2'(a);
        pp_idx_b     = 2'(b);
        result_ready = rr;
        @(posedge clk);
        if (m_phase == 2) begin
            if (rr) begin
                $display("result taken: value=%h dup=%0d", model_sum(), model_dup());
                mq.delete();
                m_phase = 0;
            end
        end else if (v) begin
            mq.push_back('{d, a, b});
            m_phase = (mq.size() == 16) ? 2 : 1;
        end
        #1 check_outputs("step");
    endtask

    task automatic idle_step(input logic rr);
        step(1'b0, $urandom, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), rr);
    endtask

    task automatic send_pend(input bit gaps, input bit shuffle);
        if (shuffle) begin
            for (int k = pend.size() - 1; k > 0; k--) begin
                int  r;
                pp_t t;
                r = int'($urandom_range(k, 0));
                t = pend[k]; pend[k] = pend[r]; pend[r] = t;
            end
        end
        foreach (pend[k]) begin
            int n = 0;
            while (gaps && $urandom_range(1, 0) == 1 && n < 8) begin
                idle_step($urandom_range(1, 0) == 1);
                n++;
            end
            step(1'b1, pend[k].d, pend[k].a, pend[k].b, $urandom_range(1, 0) == 1);
        end
        pend.delete();
    endtask

    // Hold the result for `hold` cycles (optionally with pp_valid high), then take it
    task automatic take_result(input int hold, input bit vhigh);
        for (int k = 0; k < hold; k++) begin
            step(vhigh, $urandom, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'b0);
        end
        step(1'b0, 32'h0, 0, 0, 1'b1);
    endtask

    task automatic fill_all(input logic [31:0] d);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                pend.push_back('{d, i, j});
    endtask

    initial begin
        rst_n        = 1'b0;
        pp_valid     = 1'b0;
        pp_data      = '0;
        pp_idx_a     = '0;
        pp_idx_b     = '0;
        result_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Only (0,0) = 1
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                pend.push_back('{(i == 0 && j == 0) ? 32'h1 : 32'h0, i, j});
        send_pend(1'b0, 1'b0);
        chk("single.result", result, 128'h1);
        chk("single.err", {127'b0, err}, 128'h0);
        take_result(0, 1'b0);

        // A = B = 2^64-1 in random order
        fill_all(32'hFFFE_0001);
        send_pend(1'b0, 1'b1);
        chk("allones.result", result, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        take_result(2, 1'b0);

        // (3,3) only, result held 5 cycles with pp_valid high
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                pend.push_back('{(i == 3 && j == 3) ? 32'hFFFF_FFFF : 32'h0, i, j});
        send_pend(1'b0, 1'b1);
        chk("top.result", result, 128'hFFFF_FFFF << 96);
        take_result(5, 1'b1);
        chk("top.idle", {127'b0, busy}, 128'h0);

        // Duplicate (1,2), (3,3) missing
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (!(i == 3 && j == 3)) pend.push_back('{32'h1, i, j});
        pend.push_back('{32'h1, 1, 2});
        send_pend(1'b0, 1'b1);
        chk("dup.err", {127'b0, err}, 128'h1);
        take_result(1, 1'b0);

        // Reset after 7 accepts, then a fresh set of ones
        for (int k = 0; k < 7; k++)
            step(1'b1, $urandom, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'b0);
        @(negedge clk);
        pp_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        m_phase = 0;
        check_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        fill_all(32'h1);
        send_pend(1'b0, 1'b1);
        chk("fresh.result", result, 128'h0001_0002_0003_0004_0003_0002_0001);
        take_result(0, 1'b0);

        // Gapped stream with pp_valid high during finish
        fill_all(32'hFFFE_0001);
        send_pend(1'b1, 1'b1);
        chk("gapped.result", result, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        take_result(4, 1'b1);

        // Random data, random order, random gaps and holds
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    pend.push_back('{$urandom, i, j});
            send_pend(1'b1, 1'b1);
            take_result(int'($urandom_range(4, 0)), $urandom_range(1, 0) == 1);
        end

        // Reset in finish discards the held result
        fill_all(32'h1);
        send_pend(1'b0, 1'b0);
        @(negedge clk);
        pp_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        m_phase = 0;
        check_outputs("finish_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle_step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
